// File: rtl/fir_pkg.sv
// Shared types, sizing and default taps for the FIR coefficient controller.
// DEFAULT_COEF is the symmetric 17-tap low-pass set loaded on reset.
package fir_pkg;

   localparam int WIDTH     = 16;
   localparam int ORDER     = 16;
   localparam int NTAPS     = ORDER + 1;
   localparam int ADDR_W    = 5;
   localparam int FLUSH_CYC = 20;
   localparam int ARM_TMO   = 255;
   localparam int CNT_W     = 8;

   typedef logic signed [WIDTH-1:0] coef_t;
   typedef logic [ADDR_W-1:0]       addr_t;
   typedef logic [CNT_W-1:0]        cnt_t;

   localparam cnt_t FLUSH_LAST = cnt_t'(FLUSH_CYC - 1);
   localparam cnt_t ARM_LAST   = cnt_t'(ARM_TMO);

   localparam coef_t DEFAULT_COEF [NTAPS] = '{
      16'sd212,    16'sd747,    16'sd708,    -16'sd1359,
      -16'sd4406,  -16'sd3348,  16'sd5875,   16'sd19049,
      16'sd25409,
      16'sd19049,  16'sd5875,   -16'sd3348,  -16'sd4406,
      -16'sd1359,  16'sd708,    16'sd747,    16'sd212
   };

   typedef enum logic [1:0] {IDLE, ARMED, SWAP, FLUSH} ctrl_state_t;

   function automatic logic addr_valid(input addr_t a);
      return a <= addr_t'(ORDER);
   endfunction

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Host configuration bus for the coefficient controller.
// The host side is master; the controller is slave.
interface fir_coef_ctrl_if;
   import fir_pkg::*;

   logic  cfg_wr_en;
   addr_t cfg_wr_addr;
   coef_t cfg_wr_data;
   logic  cfg_wr_ready;
   logic  cfg_commit;
   logic  cfg_busy;
   logic  err_addr;

   modport master (
      output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
      input  cfg_wr_ready, cfg_busy, err_addr
   );

   modport slave (
      input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
      output cfg_wr_ready, cfg_busy, err_addr
   );

endinterface

// File: rtl/fir_coef_bank.sv
// Shadow/active tap register pair; shadow is host-written, active feeds the FIR.
// A copy strobe moves every shadow tap into active in a single edge.
module fir_coef_bank
   import fir_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  addr_t                  wr_addr,
   input  coef_t                  wr_data,
   input  logic                   copy,
   output logic [NTAPS*WIDTH-1:0] coef_flat
);

   coef_t shadow [NTAPS];
   coef_t active [NTAPS];

   // Writes and copies are mutually exclusive in time, so no forwarding is needed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) begin
            shadow[k] <= DEFAULT_COEF[k];
            active[k] <= DEFAULT_COEF[k];
         end
      end else begin
         for (int k = 0; k < NTAPS; k++) begin
            if (wr_en && wr_addr == addr_t'(k)) shadow[k] <= wr_data;
            if (copy) active[k] <= shadow[k];
         end
      end
   end

   for (genvar k = 0; k < NTAPS; k++) begin : g_flat
      assign coef_flat[k*WIDTH +: WIDTH] = active[k];
   end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Run-time coefficient manager: stages host taps, swaps at a sample gap,
// then masks FIR output validity until the pipeline holds only new-tap results.
module fir_coef_ctrl
   import fir_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   fir_coef_ctrl_if.slave         cfg,
   input  logic                   smp_valid,
   output logic [NTAPS*WIDTH-1:0] coef_flat,
   output logic                   out_valid,
   output logic                   swap_done
);

   ctrl_state_t state, state_nxt;
   cnt_t        cnt, cnt_nxt;
   logic        err_q;
   logic        wr_ready;
   logic        busy;
   logic        copy;
   logic        wr_ok;
   logic        bad_wr;

   assign wr_ok  = wr_ready & cfg.cfg_wr_en &  addr_valid(cfg.cfg_wr_addr);
   assign bad_wr = wr_ready & cfg.cfg_wr_en & ~addr_valid(cfg.cfg_wr_addr);

   // Reset lands in FLUSH so the FIR's stale pipeline is masked after power-up too
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FLUSH;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         err_q <= bad_wr;
      end
   end

   // One counter serves as ARMED timeout and FLUSH length since they never overlap
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      swap_done = 1'b0;
      copy      = 1'b0;
      case (state)
         IDLE: begin
            wr_ready  = 1'b1;
            busy      = 1'b0;
            out_valid = 1'b1;
            if (cfg.cfg_commit) begin
               state_nxt = ARMED;
               cnt_nxt   = '0;
            end
         end
         ARMED: begin
            out_valid = 1'b1;
            if (!smp_valid || cnt == ARM_LAST) begin
               state_nxt = SWAP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SWAP: begin
            swap_done = 1'b1;
            copy      = 1'b1;
            state_nxt = FLUSH;
            cnt_nxt   = '0;
         end
         FLUSH: begin
            if (cnt == FLUSH_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = FLUSH;
      endcase
   end

   assign cfg.cfg_wr_ready = wr_ready;
   assign cfg.cfg_busy     = busy;
   assign cfg.err_addr     = err_q;

   fir_coef_bank u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_ok),
      .wr_addr   (cfg.cfg_wr_addr),
      .wr_data   (cfg.cfg_wr_data),
      .copy      (copy),
      .coef_flat (coef_flat)
   );

endmodule
